dffram_bus_port: RTL

DFFRAM_BUS_PORT -- requirements
Module: dffram_bus_port

---
 rtl/dffram_bus_port.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dffram_bus_port.sv
// Valid/ready bus port onto a single-port DFFRAM: byte/half/word lanes, misalignment errors, 1/2/3-edge response (error/write/read).
// One request in flight, so req_ready is low until the response is consumed; DFFRAM_BUS_PORT_SIGNEXT_EN enables signed sub-word reads.
module dffram_bus_port #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic          req_signed,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-3:0] ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, RESP} state_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
    logic       we;
    logic       sgn;
  } req_t;

  state_t      state;
  req_t        held;
  logic        accept;
  logic        misaligned;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        sign_ext;

  assign req_ready = (state == IDLE) && !RST;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 4'b0000;
    wdata_sh   = req_wdata;
    case (req_size)
      2'b00: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        wdata_sh  = req_wdata << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        misaligned = req_addr[0];
        lane_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = req_wdata << {req_addr[1], 4'b0000};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        lane_mask  = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

`ifdef DFFRAM_BUS_PORT_SIGNEXT_EN
  assign sign_ext = held.sgn;
`else
  logic unused_sgn;
  assign unused_sgn = held.sgn;
  assign sign_ext   = 1'b0;
`endif

  // Lane selection uses the offset captured at acceptance, not the live address.
  assign rd_byte = ram_do[{held.off, 3'b000} +: 8];
  assign rd_half = held.off[1] ? ram_do[31:16] : ram_do[15:0];

  always_comb begin
    rd_ext = ram_do;
    case (held.size)
      2'b00:   rd_ext = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{sign_ext & rd_half[15]}}, rd_half};
      default: rd_ext = ram_do;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      held      <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_a     <= '0;
      ram_di    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            held <= '{size: req_size, off: req_addr[1:0], we: req_we, sgn: req_signed};
            if (misaligned) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state  <= ACCESS;
              ram_en <= 1'b1;
              ram_a  <= req_addr[AW-1:2];
              ram_we <= req_we ? lane_mask : 4'b0000;
              if (req_we) ram_di <= wdata_sh;
            end
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          if (held.we) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_ext;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
